// File: rtl/maxpool2d_11_11_64_to_5_5_64.sv
// 2x2 stride-2 signed int8 max-pool: 11x11x64 map read from the conv2 stage -> 5x5x64 map in an internal buffer.
// Reads are issued back-to-back; a two-stage tag pipeline lines each window element up with its returning src_data.
module maxpool2d_11_11_64_to_5_5_64 #(
    parameter int IN_DIM  = 11,
    parameter int OUT_DIM = 5,
    parameter int CH      = 64,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [31:0]   src_addr,
    input  logic [DW-1:0] src_data,
    input  logic [31:0]   read_addr,
    output logic [DW-1:0] read_data,
    output logic          done,
    output logic          busy
);
    localparam int unsigned OUT_WORDS = OUT_DIM * OUT_DIM * CH;
    localparam int unsigned IN_WORDS  = IN_DIM * IN_DIM * CH;
    localparam int unsigned PW        = $clog2(OUT_DIM);
    localparam int unsigned CW        = $clog2(CH);
    localparam int unsigned AW        = $clog2(IN_WORDS);
    localparam int unsigned OW        = $clog2(OUT_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q;
    logic [PW-1:0]  pr_q, pc_q, pr_d, pc_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [1:0]     el_q, el_d;
    logic [AW-1:0]  src_addr_q, src_addr_d;
    logic [OW-1:0]  oaddr_d;
    logic           last_c;
    logic           done_q, busy_q;

    // Tags for the address currently presented (iss) and for the data arriving this cycle (dat).
    logic           iss_v_q, dat_v_q;
    logic [1:0]     iss_el_q, dat_el_q;
    logic [OW-1:0]  iss_oa_q, dat_oa_q;

    logic [DW-1:0]  max_q, max_d;
    logic [DW-1:0]  mem_q [OUT_WORDS];
    logic [DW-1:0]  read_data_q;

    // Next read in issue order: window element innermost, then channel, then pooled column, then row.
    always_comb begin
        pr_d = pr_q;
        pc_d = pc_q;
        ch_d = ch_q;
        el_d = el_q + 2'd1;
        if (el_q == 2'd3) begin
            if (ch_q == CW'(CH - 1)) begin
                ch_d = '0;
                if (pc_q == PW'(OUT_DIM - 1)) begin
                    pc_d = '0;
                    pr_d = pr_q + PW'(1);
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end else begin
                ch_d = ch_q + CW'(1);
            end
        end
        last_c = (el_q == 2'd3) && (ch_q == CW'(CH - 1)) &&
                 (pc_q == PW'(OUT_DIM - 1)) && (pr_q == PW'(OUT_DIM - 1));
        src_addr_d = ((AW'({pr_d, 1'b0}) + AW'(el_d[1])) * AW'(IN_DIM) +
                      AW'({pc_d, 1'b0}) + AW'(el_d[0])) * AW'(CH) + AW'(ch_d);
        oaddr_d = (OW'(pr_d) * OW'(OUT_DIM) + OW'(pc_d)) * OW'(CH) + OW'(ch_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pr_q       <= '0;
            pc_q       <= '0;
            ch_q       <= '0;
            el_q       <= '0;
            src_addr_q <= '0;
            iss_v_q    <= 1'b0;
            iss_el_q   <= '0;
            iss_oa_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        pr_q       <= '0;
                        pc_q       <= '0;
                        ch_q       <= '0;
                        el_q       <= '0;
                        src_addr_q <= '0;
                        iss_v_q    <= 1'b1;
                        iss_el_q   <= '0;
                        iss_oa_q   <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_c) begin
                        state_q <= DRAIN;
                        iss_v_q <= 1'b0;
                    end else begin
                        pr_q       <= pr_d;
                        pc_q       <= pc_d;
                        ch_q       <= ch_d;
                        el_q       <= el_d;
                        src_addr_q <= src_addr_d;
                        iss_v_q    <= 1'b1;
                        iss_el_q   <= el_d;
                        iss_oa_q   <= oaddr_d;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Element 0 loads the running max; later elements replace it only when strictly greater.
    always_comb begin
        max_d = max_q;
        if (dat_el_q == 2'd0 || $signed(src_data) > $signed(max_q)) begin
            max_d = src_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_v_q  <= 1'b0;
            dat_el_q <= '0;
            dat_oa_q <= '0;
            max_q    <= '0;
        end else begin
            dat_v_q  <= iss_v_q;
            dat_el_q <= iss_el_q;
            dat_oa_q <= iss_oa_q;
            if (dat_v_q) begin
                max_q <= max_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dat_v_q && dat_el_q == 2'd3) begin
            mem_q[dat_oa_q] <= max_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else if (read_addr < 32'(OUT_WORDS)) begin
            read_data_q <= mem_q[read_addr[OW-1:0]];
        end else begin
            read_data_q <= '0;
        end
    end

    assign src_addr  = 32'(src_addr_q);
    assign read_data = read_data_q;
    assign done      = done_q;
    assign busy      = busy_q;
endmodule
